// File: rtl/secded_decoder_72_64_if.sv
// Codeword-in / decoded-word-out stream bundle for the SEC-DED (72,64) decoder.
// The decoder connects through the slave modport. The codeword producer and the data consumer connect through the master modport.
interface secded_decoder_72_64_if;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] in_code;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_ce;
    logic        out_ue;
    logic [7:0]  out_syndrome;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_data, out_ce, out_ue, out_syndrome
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_data, out_ce, out_ue, out_syndrome
    );
endinterface

// File: rtl/secded_decoder_72_64.sv
// Two-stage SEC-DED (72,64) decoder: S1 registers codeword/syndrome/parity, S2 classifies and corrects.
// Also keeps saturating CE/UE counters and a sticky log of the first uncorrectable syndrome.
module secded_decoder_72_64 #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    secded_decoder_72_64_if.slave bus,
    input  logic                 clr_stats,
    output logic [CNT_W-1:0]     ce_count,
    output logic [CNT_W-1:0]     ue_count,
    output logic                 ue_log_valid,
    output logic [7:0]           ue_log_syn
);
    logic        stall;
    logic        deliver;
    logic [6:0]  syn_c;
    logic        par_c;
    logic        s1_valid;
    logic [71:0] s1_code;
    logic [6:0]  s1_syn;
    logic        s1_par;
    logic        ce_c;
    logic        ue_c;
    logic [71:0] fixed_c;
    logic [63:0] data_c;
    logic [5:0]  j;

    assign stall       = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall;
    assign deliver     = bus.out_valid && bus.out_ready;

    always_comb begin
        syn_c = '0;
        for (int unsigned i = 1; i < 72; i++) begin
            if (bus.in_code[i[6:0]]) syn_c = syn_c ^ i[6:0];
        end
        par_c = ^bus.in_code;
    end

    // Syndrome 0 with odd parity flips bit 0, which leaves the data untouched.
    always_comb begin
        ce_c    = s1_par && (s1_syn <= 7'd71);
        ue_c    = (s1_par && (s1_syn > 7'd71)) || (!s1_par && (s1_syn != '0));
        fixed_c = s1_code;
        if (ce_c) fixed_c[s1_syn] = ~s1_code[s1_syn];
        data_c = '0;
        j      = '0;
        for (int unsigned i = 3; i < 72; i++) begin
            if ((i & (i - 1)) != 0) begin
                data_c[j] = fixed_c[i[6:0]];
                j         = j + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (!stall) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_code <= bus.in_code;
                s1_syn  <= syn_c;
                s1_par  <= par_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid    <= 1'b0;
            bus.out_data     <= '0;
            bus.out_ce       <= 1'b0;
            bus.out_ue       <= 1'b0;
            bus.out_syndrome <= '0;
        end else if (!stall) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_data     <= data_c;
                bus.out_ce       <= ce_c;
                bus.out_ue       <= ue_c;
                bus.out_syndrome <= {s1_par, s1_syn};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_count     <= '0;
            ue_count     <= '0;
            ue_log_valid <= 1'b0;
            ue_log_syn   <= '0;
        end else if (clr_stats) begin
            ce_count     <= '0;
            ue_count     <= '0;
            ue_log_valid <= 1'b0;
            ue_log_syn   <= '0;
        end else if (deliver) begin
            if (bus.out_ce && (ce_count != '1)) ce_count <= ce_count + 1'b1;
            if (bus.out_ue && (ue_count != '1)) ue_count <= ue_count + 1'b1;
            if (bus.out_ue && !ue_log_valid) begin
                ue_log_valid <= 1'b1;
                ue_log_syn   <= bus.out_syndrome;
            end
        end
    end
endmodule

// File: tb/tb_secded_decoder_72_64.sv
// Randomized self-checking bench for secded_decoder_72_64 (CNT_W=2 so saturation is reachable).
// Uses a spec-level encoder and reference decoder with saturating counter/log models.
module tb_secded_decoder_72_64;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned CMAX  = 3;

    typedef struct packed {
        logic [63:0] data;
        logic        ce;
        logic        ue;
        logic [7:0]  syn;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr_stats = 1'b0;
    logic [CNT_W-1:0] ce_count;
    logic [CNT_W-1:0] ue_count;
    logic             ue_log_valid;
    logic [7:0]       ue_log_syn;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned ce_m = 0;
    int unsigned ue_m = 0;
    logic        log_v_m = 1'b0;
    logic [7:0]  log_s_m = '0;

    secded_decoder_72_64_if bus();

    secded_decoder_72_64 #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .clr_stats    (clr_stats),
        .ce_count     (ce_count),
        .ue_count     (ue_count),
        .ue_log_valid (ue_log_valid),
        .ue_log_syn   (ue_log_syn)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [71:0] encode(input logic [63:0] d);
        logic [71:0] c = '0;
        int unsigned j = 0;
        int unsigned s = 0;
        for (int unsigned p = 1; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p[6:0]] = d[j[5:0]];
                j++;
            end
        end
        for (int unsigned p = 1; p < 72; p++) if (c[p[6:0]]) s = s ^ p;
        for (int unsigned k = 0; k < 7; k++) if (s[k]) c[7'(1 << k)] = 1'b1;
        c[0] = ^c[71:1];
        return c;
    endfunction

    function automatic res_t ref_decode(input logic [71:0] c);
        res_t        r;
        int unsigned s = 0;
        int unsigned j = 0;
        logic        par;
        logic [71:0] f = c;
        for (int unsigned p = 1; p < 72; p++) if (c[p[6:0]]) s = s ^ p;
        par  = ^c;
        r.ce = par && (s <= 71);
        r.ue = (par && (s > 71)) || (!par && (s != 0));
        if (r.ce) f[s[6:0]] = ~f[s[6:0]];
        r.syn  = {par, s[6:0]};
        r.data = '0;
        for (int unsigned p = 3; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                r.data[j[5:0]] = f[p[6:0]];
                j++;
            end
        end
        return r;
    endfunction

    function automatic res_t observe();
        res_t o;
        o.data = bus.out_data;
        o.ce   = bus.out_ce;
        o.ue   = bus.out_ue;
        o.syn  = bus.out_syndrome;
        return o;
    endfunction

    task automatic note_delivery(input res_t r);
        if (r.ce && ce_m < CMAX) ce_m++;
        if (r.ue && ue_m < CMAX) ue_m++;
        if (r.ue && !log_v_m) begin
            log_v_m = 1'b1;
            log_s_m = r.syn;
        end
    endtask

    task automatic note_clear();
        ce_m = 0; ue_m = 0; log_v_m = 1'b0; log_s_m = '0;
    endtask

    task automatic pulse_clear();
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
        note_clear();
    endtask

    // Sends one word into an empty pipeline. Returns the outputs and the cycles until out_valid.
    task automatic send_one(input logic [71:0] code, output res_t obs, output int lat);
        bus.in_valid = 1'b1;
        bus.in_code  = code;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        obs = '0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
        end
        obs = observe();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({bus.out_valid, bus.out_ce, bus.out_ue, bus.out_syndrome, bus.out_data} !== '0 || bus.in_ready !== 1'b1)
            begin n_bad++; $display("FAIL reset_outputs: got v=%b rdy=%b data=%h syn=%h expected zeros with rdy=1",
                bus.out_valid, bus.in_ready, bus.out_data, bus.out_syndrome); end
        n_cmp++;
        if (ce_count !== '0 || ue_count !== '0 || ue_log_valid !== 1'b0 || ue_log_syn !== '0)
            begin n_bad++; $display("FAIL reset_stats: got ce=%0d ue=%0d log=%b/%h expected 0", ce_count, ue_count, ue_log_valid, ue_log_syn); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            begin n_bad++; $display("FAIL post_reset: got v=%b rdy=%b expected v=0 rdy=1", bus.out_valid, bus.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_clean();
        res_t obs; int lat;
        send_one(72'h0, obs, lat);
        n_cmp++;
        if (obs !== res_t'({64'h0, 1'b0, 1'b0, 8'h00}) || lat != 2)
            begin n_bad++; $display("FAIL clean_word: got %h lat=%0d expected data=0 ce=0 ue=0 syn=00 lat=2", obs, lat); end
        n_cmp++;
        if (ce_count !== CNT_W'(ce_m) || ue_count !== CNT_W'(ue_m))
            begin n_bad++; $display("FAIL clean_counters: got ce=%0d ue=%0d expected %0d/%0d", ce_count, ue_count, ce_m, ue_m); end
    endtask

    task automatic test_single_sweep();
        res_t obs, exp; int lat;
        logic [63:0] d; logic [71:0] c;
        pulse_clear();
        c = 72'h0; c[3] = 1'b1;
        send_one(c, obs, lat);
        note_delivery(ref_decode(c));
        n_cmp++;
        if (obs !== res_t'({64'h0, 1'b1, 1'b0, 8'h83}) || lat != 2)
            begin n_bad++; $display("FAIL single_bit3: got %h lat=%0d expected data=0 ce=1 syn=83", obs, lat); end
        n_cmp++;
        if (ce_count !== 2'd1)
            begin n_bad++; $display("FAIL single_bit3_count: got %0d expected 1", ce_count); end
        for (int unsigned pos = 0; pos < 72; pos++) begin
            d = {$urandom, $urandom};
            c = encode(d);
            c[pos[6:0]] = ~c[pos[6:0]];
            exp = ref_decode(c);
            send_one(c, obs, lat);
            note_delivery(exp);
            n_cmp++;
            if (obs.data !== d || obs.ce !== 1'b1 || obs.ue !== 1'b0 || obs.syn !== {1'b1, pos[6:0]} || lat != 2)
                begin n_bad++; $display("FAIL single_sweep pos=%0d: got %h lat=%0d expected data=%h ce=1 syn=%h", pos, obs, lat, d, {1'b1, pos[6:0]}); end
            n_cmp++;
            if (obs !== exp || ce_count !== CNT_W'(ce_m))
                begin n_bad++; $display("FAIL single_ref pos=%0d: got %h ce_cnt=%0d expected %h ce_cnt=%0d", pos, obs, ce_count, exp, ce_m); end
        end
    endtask

    task automatic test_double();
        res_t obs, exp; int lat;
        logic [71:0] c;
        int unsigned a, b;
        pulse_clear();
        c = 72'h0; c[3] = 1'b1; c[5] = 1'b1;
        send_one(c, obs, lat);
        note_delivery(ref_decode(c));
        n_cmp++;
        if (obs !== res_t'({64'h3, 1'b0, 1'b1, 8'h06}) || lat != 2)
            begin n_bad++; $display("FAIL double_3_5: got %h lat=%0d expected data=3 ue=1 syn=06", obs, lat); end
        n_cmp++;
        if (ue_count !== 2'd1 || ce_count !== 2'd0 || ue_log_valid !== 1'b1 || ue_log_syn !== 8'h06)
            begin n_bad++; $display("FAIL double_stats: got ue=%0d ce=%0d log=%b/%h expected 1/0/1/06", ue_count, ce_count, ue_log_valid, ue_log_syn); end
        c = 72'h0; c[9] = 1'b1; c[10] = 1'b1;
        send_one(c, obs, lat);
        note_delivery(ref_decode(c));
        n_cmp++;
        if (obs !== res_t'({64'h30, 1'b0, 1'b1, 8'h03}) || ue_count !== 2'd2 || ue_log_syn !== 8'h06)
            begin n_bad++; $display("FAIL double_9_10: got %h ue=%0d log=%h expected data=30 syn=03 ue=2 log=06", obs, ue_count, ue_log_syn); end
        c = 72'h0; c[64] = 1'b1; c[8] = 1'b1; c[1] = 1'b1;
        send_one(c, obs, lat);
        note_delivery(ref_decode(c));
        n_cmp++;
        if (obs !== res_t'({64'h0, 1'b0, 1'b1, 8'hC9}) || ue_count !== 2'd3)
            begin n_bad++; $display("FAIL ue_syn_over_71: got %h ue=%0d expected ue=1 syn=c9 ue_cnt=3", obs, ue_count); end
        for (int k = 0; k < 10; k++) begin
            a = $urandom_range(71);
            b = (a + 1 + $urandom_range(70)) % 72;
            c = encode({$urandom, $urandom});
            c[a[6:0]] = ~c[a[6:0]];
            c[b[6:0]] = ~c[b[6:0]];
            exp = ref_decode(c);
            send_one(c, obs, lat);
            note_delivery(exp);
            n_cmp++;
            if (obs !== exp || obs.ue !== 1'b1 || obs.ce !== 1'b0 || ue_count !== CNT_W'(ue_m) || ue_log_syn !== 8'h06)
                begin n_bad++; $display("FAIL double_rand %0d,%0d: got %h ue=%0d log=%h expected %h ue=%0d log=06", a, b, obs, ue_count, ue_log_syn, exp, ue_m); end
        end
    endtask

    task automatic test_saturation_clear();
        res_t obs; int lat; int w;
        logic [71:0] c;
        pulse_clear();
        for (int k = 0; k < 5; k++) begin
            c = encode({$urandom, $urandom});
            c[k + 10] = ~c[k + 10];
            send_one(c, obs, lat);
            note_delivery(ref_decode(c));
        end
        n_cmp++;
        if (ce_count !== 2'd3 || ce_m != 3)
            begin n_bad++; $display("FAIL ce_saturate: got %0d expected 3", ce_count); end
        for (int mode = 0; mode < 2; mode++) begin
            c = encode({$urandom, $urandom});
            c[20] = ~c[20];
            if (mode == 1) c[30] = ~c[30];
            bus.in_valid = 1'b1;
            bus.in_code  = c;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            w = 0;
            while (w < 8) begin
                @(negedge clk);
                w++;
                if (bus.out_valid) break;
            end
            clr_stats = 1'b1;
            @(posedge clk); #1;
            clr_stats = 1'b0;
            note_clear();
            n_cmp++;
            if (w >= 8 || ce_count !== '0 || ue_count !== '0 || ue_log_valid !== 1'b0 || ue_log_syn !== '0)
                begin n_bad++; $display("FAIL clear_wins mode=%0d: got wait=%0d ce=%0d ue=%0d log=%b/%h expected all 0", mode, w, ce_count, ue_count, ue_log_valid, ue_log_syn); end
        end
        c = 72'h0; c[6] = 1'b1; c[7] = 1'b1;
        send_one(c, obs, lat);
        note_delivery(ref_decode(c));
        n_cmp++;
        if (ue_count !== 2'd1 || ue_log_valid !== 1'b1 || ue_log_syn !== 8'h01)
            begin n_bad++; $display("FAIL after_clear_ue: got ue=%0d log=%b/%h expected 1/1/01", ue_count, ue_log_valid, ue_log_syn); end
    endtask

    // mode 0: four back-to-back words with a 3-cycle consumer stall; mode 1: random valid/ready.
    task automatic run_stream(input int mode, input int n);
        res_t q[$];
        res_t held_v, obs, exp;
        logic held = 1'b0;
        logic acc;
        logic [71:0] c;
        int sent = 0, got = 0, cyc = 0, stalls = 0, nflip;
        int unsigned a, b;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (got < n && cyc < 4000) begin
            if (!bus.in_valid && sent < n && (mode == 0 || $urandom_range(3) != 0)) begin
                c = encode({$urandom, $urandom});
                nflip = $urandom_range(2);
                a = $urandom_range(71);
                b = (a + 1 + $urandom_range(70)) % 72;
                if (nflip >= 1) c[a[6:0]] = ~c[a[6:0]];
                if (nflip == 2) c[b[6:0]] = ~c[b[6:0]];
                bus.in_code  = c;
                bus.in_valid = 1'b1;
            end
            bus.out_ready = (mode == 0) ? !(cyc >= 2 && cyc <= 4) : ($urandom_range(9) < 7);
            @(negedge clk);
            obs = observe();
            acc = bus.in_valid && bus.in_ready;
            n_cmp++;
            if (bus.in_ready !== !(bus.out_valid && !bus.out_ready))
                begin n_bad++; $display("FAIL in_ready cyc=%0d: got %b expected %b", cyc, bus.in_ready, !(bus.out_valid && !bus.out_ready)); end
            if (held) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || obs !== held_v)
                    begin n_bad++; $display("FAIL stall_stable cyc=%0d: got v=%b %h expected v=1 %h", cyc, bus.out_valid, obs, held_v); end
            end
            if (mode == 0 && cyc == 2) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1)
                    begin n_bad++; $display("FAIL first_latency: got out_valid=%b expected 1", bus.out_valid); end
            end
            n_cmp++;
            if (ce_count !== CNT_W'(ce_m) || ue_count !== CNT_W'(ue_m) || ue_log_valid !== log_v_m || ue_log_syn !== log_s_m)
                begin n_bad++; $display("FAIL stream_stats cyc=%0d: got ce=%0d ue=%0d log=%b/%h expected %0d/%0d/%b/%h",
                    cyc, ce_count, ue_count, ue_log_valid, ue_log_syn, ce_m, ue_m, log_v_m, log_s_m); end
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL stream_extra cyc=%0d: got unexpected word %h expected none", cyc, obs);
                end else begin
                    exp = q.pop_front();
                    if (obs !== exp)
                        begin n_bad++; $display("FAIL stream_word %0d: got %h expected %h", got, obs, exp); end
                    note_delivery(exp);
                    got++;
                end
            end
            held   = bus.out_valid && !bus.out_ready;
            held_v = obs;
            if (held) stalls++;
            if (acc) begin
                q.push_back(ref_decode(bus.in_code));
                sent++;
            end
            @(posedge clk); #1;
            if (acc) bus.in_valid = 1'b0;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_cmp++;
        if (got != n || q.size() != 0)
            begin n_bad++; $display("FAIL stream_complete mode=%0d: got %0d delivered %0d pending expected %0d/0", mode, got, q.size(), n); end
        if (mode == 0) begin
            n_cmp++;
            if (stalls != 3)
                begin n_bad++; $display("FAIL stall_cycles: got %0d expected 3", stalls); end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midstream();
        res_t obs; int lat; int seen;
        logic [71:0] c;
        c = encode(64'h1234);
        c[40] = ~c[40];
        send_one(c, obs, lat);
        note_delivery(ref_decode(c));
        n_cmp++;
        if (ce_count === '0 || ce_count !== CNT_W'(ce_m))
            begin n_bad++; $display("FAIL pre_reset_ce: got %0d expected %0d (nonzero)", ce_count, ce_m); end
        bus.in_valid = 1'b1;
        bus.in_code  = c;
        @(posedge clk); #1;
        bus.in_code = encode(64'hABCD);
        @(posedge clk); #2;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        note_clear();
        #1;
        n_cmp++;
        if ({bus.out_valid, bus.out_ce, bus.out_ue, bus.out_syndrome, bus.out_data} !== '0 || bus.in_ready !== 1'b1)
            begin n_bad++; $display("FAIL midreset_outputs: got v=%b data=%h syn=%h rdy=%b expected zeros rdy=1",
                bus.out_valid, bus.out_data, bus.out_syndrome, bus.in_ready); end
        n_cmp++;
        if (ce_count !== '0 || ue_count !== '0 || ue_log_valid !== 1'b0 || ue_log_syn !== '0)
            begin n_bad++; $display("FAIL midreset_stats: got ce=%0d ue=%0d log=%b/%h expected 0", ce_count, ue_count, ue_log_valid, ue_log_syn); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        n_cmp++;
        if (seen != 0)
            begin n_bad++; $display("FAIL midreset_ghost: got %0d valid cycles expected 0", seen); end
        @(posedge clk); #1;
        c = encode(64'hFEED_F00D_0000_0001);
        send_one(c, obs, lat);
        note_delivery(ref_decode(c));
        n_cmp++;
        if (lat != 2 || obs !== res_t'({64'hFEED_F00D_0000_0001, 1'b0, 1'b0, 8'h00}))
            begin n_bad++; $display("FAIL post_reset_word: got %h lat=%0d expected clean feedf00d00000001 lat=2", obs, lat); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_code   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        test_reset();
        test_clean();
        test_single_sweep();
        test_double();
        test_saturation_clear();
        run_stream(0, 4);
        run_stream(1, 200);
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/secded_decoder_72_64.md
Name: secded_decoder_72_64

Overview:
- Pipelined SEC-DED (72,64) decoder/checker.
- Sits directly downstream of the 72-bit fault-injection stage: consumes possibly corrupted codewords, corrects single-bit errors and detects double-bit errors.
- Delivers 64-bit data with per-word status.
- Keeps saturating error counters and a sticky log of the first uncorrectable syndrome for the cache controller.

Parameters:
CNT_W, 16, width of the correctable and uncorrectable error counters (saturating).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  codeword on in_code is valid
in_ready  output  1  decoder accepts codeword this cycle
in_code  input  72  codeword; bit 0 overall parity, bits 71:1 Hamming positions 1..71
out_valid  output  1  decoded word valid
out_ready  input  1  consumer accepts out_* this cycle
out_data  output  64  corrected data
out_ce  output  1  single error corrected (data or check bit)
out_ue  output  1  uncorrectable error; out_data is raw extracted data
out_syndrome  output  8  {overall parity, syndrome[6:0]} for this word
ce_count  output  CNT_W  saturating count of accepted-and-delivered CE words
ue_count  output  CNT_W  saturating count of delivered UE words
ue_log_valid  output  1  sticky: a UE has been logged
ue_log_syn  output  8  out_syndrome of the first UE since last clear
clr_stats  input  1  synchronous clear of counters and UE log

Behaviour:
- Code layout:
  - Check bits sit at positions 1,2,4,8,16,32,64.
  - Data bits fill the remaining positions 3,5,6,7,9,... ascending, with data[0] at position 3 and data[63] at position 71.
  - Bit 0 makes XOR of all 72 bits = 0.
- Stage 1 (S1) registers the 72-bit codeword, syndrome s = XOR of indices i (1..71) where in_code[i]=1, and p = XOR of all 72 bits.
- Stage 2 (S2) classifies, corrects and registers outputs. Latency is exactly 2 cycles from accept to out_valid with no stall.
- Classification:
  - s=0,p=0: clean.
  - p=1, s=0: CE, parity bit 0 in error, data unchanged.
  - p=1, 1<=s<=71: CE, flip position s. If s is a check position, data is unchanged.
  - p=1, s>71: UE.
  - p=0, s!=0: UE (double error).
  - out_ce and out_ue are never both 1.
- Handshake:
  - Transfer on valid&&ready at each interface.
  - stall = out_valid && !out_ready; in_ready = !stall.
  - On stall both stages hold their contents; out_* stay stable until accepted.
  - S1 captures in_valid&&in_ready each non-stalled cycle. Bubbles propagate as invalid.
  - Full throughput: 1 word/cycle when out_ready=1.
- Counters:
  - Increment when the word leaves S2 (out_valid&&out_ready) with out_ce or out_ue set.
  - Saturate at 2^CNT_W-1; no wrap.
  - If clr_stats is asserted in the same cycle as an increment, clear wins (result 0).
- UE log:
  - On first delivered UE while ue_log_valid=0, set ue_log_valid=1 and capture out_syndrome.
  - Later UEs do not overwrite the log.
  - clr_stats clears the log; clear wins over a simultaneous capture.
- Reset (async assert, sync-safe deassert per codebase practice):
  - All pipeline valids, out_data, out_ce, out_ue, out_syndrome, counters and log are 0.
  - in_ready=1.
  - Reset mid-operation discards in-flight words silently with no partial output.
- X-free: out_data holds its last value when out_valid=0; the bench checks out_data only when out_valid=1.

Test Plan:
- Clean word: in_code=72'h0, out_ready=1 -> 2 cycles later out_data=0, out_ce=0, out_ue=0, out_syndrome=8'h00, counters unchanged.
- Single data error: in_code bit 3 set -> out_syndrome=8'h83, out_ce=1, out_data=0, ce_count=1. Sweep every position 0..71 singly; each gives out_ce=1 and data restored.
- Double error: bits 3 and 5 set -> out_syndrome=8'h06, out_ue=1, out_data=64'h3, ue_count=1, ue_log_valid=1, ue_log_syn=8'h06. A second UE with bits 9,10 leaves ue_log_syn=8'h06.
- Backpressure: stream 4 words with out_ready=0 for 3 cycles after first out_valid -> in_ready=0 during stall, out_* stable, all 4 words delivered in order with no loss or duplication.
- Saturation/clear with CNT_W=2: 5 CE words -> ce_count=3. clr_stats coincident with a CE delivery -> ce_count=0.
- Reset mid-stream: assert rst_n=0 with both stages full -> outputs, counters and log read 0 immediately. After release, first new word appears 2 cycles after acceptance.
